frame_streamer: RTL and testbench

- Source side of the serial-image protocol used by the windowers.
- Accepts frame words from an upstream writer over a valid/ready handshake into a ping-pong (two-bank) buffer.
- Replays each complete frame as one uninterrupted burst of 2^(LOG2_IMG_SIZE+log2(SER_CYC)) words, so the downstream windower sees a contiguous stream after its first valid.
- Inter-frame idle gaps are enforced so the windower can flush its padding between frames.

---
 rtl/frame_streamer.sv | 165 ++++++++++++++++
 tb/tb_frame_streamer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
// frame_streamer: ping-pong frame buffer feeding the serial-image windowers.
// Upstream words are written into two alternating banks; each complete bank
// is replayed as one uninterrupted burst followed by GAP idle cycles so the
// downstream windower can flush its padding between frames.
// Optional feature: define FRAME_STREAMER_CNT_EN to add the 16-bit frame_cnt
// output (counts emitted frames, wraps at 2^16).
// Handshake: a word moves when wr_vld && wr_rdy at a rising clk edge; wr_vld
// may rise or fall at any time, wr_rdy depends only on the buffer state.
module frame_streamer #(
    parameter int NO_CH         = 2,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int SER_CYC       = 1,
    parameter int GAP           = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [NO_CH-1:0] wr_data,
    output logic             vld_out,
    output logic [NO_CH-1:0] data_out,
    output logic             sof,
    output logic             eof
`ifdef FRAME_STREAMER_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    // Words per frame: samples times serialization slots, both powers of 2.
    localparam int SW    = (SER_CYC > 1) ? $clog2(SER_CYC) : 0;
    localparam int AW    = LOG2_IMG_SIZE + SW;
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [AW-1:0] LAST = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    // Bank b occupies addresses {b, ptr}.
    logic [NO_CH-1:0] mem [0:(2**(AW+1))-1];

    logic [1:0]    full;
    logic          wbank;
    logic [AW-1:0] wptr;
    logic          rbank;
    logic [AW-1:0] rptr;
    logic [1:0]    state;
    logic [GW-1:0] gap_cnt;

    logic wr_fire;
    logic wr_last;
    logic rd_last;

    // A bank being read is always full, so it can never be written.
    assign wr_rdy  = !full[wbank];
    assign wr_fire = wr_vld && wr_rdy;
    assign wr_last = wr_fire && (wptr == LAST);
    assign rd_last = (state == S_STREAM) && (rptr == LAST);

    // Frame storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wbank, wptr}] <= wr_data;
        end
    end

    // Write pointer and bank selection; a partial frame is dropped by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            wbank <= 1'b0;
        end else if (wr_fire) begin
            if (wptr == LAST) begin
                wptr  <= '0;
                wbank <= ~wbank;
            end else begin
                wptr <= wptr + 1'b1;
            end
        end
    end

    // Per-bank full flags: set by the writer, cleared by the reader on eof.
    // The two never target the same bank in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            if (wr_last) begin
                full[wbank] <= 1'b1;
            end
            if (rd_last) begin
                full[rbank] <= 1'b0;
            end
        end
    end

    // Read FSM: wait for a full bank, stream it without stalls, then idle GAP cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rptr     <= '0;
            rbank    <= 1'b0;
            gap_cnt  <= '0;
            vld_out  <= 1'b0;
            sof      <= 1'b0;
            eof      <= 1'b0;
            data_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    vld_out <= 1'b0;
                    sof     <= 1'b0;
                    eof     <= 1'b0;
                    if (full[rbank]) begin
                        rptr  <= '0;
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    data_out <= mem[{rbank, rptr}];
                    vld_out  <= 1'b1;
                    sof      <= (rptr == '0);
                    eof      <= (rptr == LAST);
                    if (rptr == LAST) begin
                        rptr    <= '0;
                        rbank   <= ~rbank;
                        gap_cnt <= GW'(GAP - 1);
                        state   <= S_GAP;
                    end else begin
                        rptr <= rptr + 1'b1;
                    end
                end
                S_GAP: begin
                    vld_out <= 1'b0;
                    sof     <= 1'b0;
                    eof     <= 1'b0;
                    if (gap_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    vld_out <= 1'b0;
                    sof     <= 1'b0;
                    eof     <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_STREAMER_CNT_EN
    // Count frames at the edge that registers their eof word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (rd_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: scoreboard bench for frame_streamer (8 words per frame).
// The reference model works on whole frames: accepted words collect into a
// frame, a complete frame is queued for output together with the edge it
// becomes available, and a monitor checks data, markers, start timing, gaps,
// wr_rdy (at most two frames held) and the optional frame counter.
module tb_frame_streamer;

    localparam int NO_CH         = 8;
    localparam int LOG2_IMG_SIZE = 2;
    localparam int SER_CYC       = 2;
    localparam int GAP           = 2;
    localparam int DEPTH         = (2 ** LOG2_IMG_SIZE) * SER_CYC;

    // Clock and reset
    logic             clk = 1'b0;
    logic             rst;
    logic             wr_vld;
    logic             wr_rdy;
    logic [NO_CH-1:0] wr_data;
    logic             vld_out;
    logic [NO_CH-1:0] data_out;
    logic             sof;
    logic             eof;
`ifdef FRAME_STREAMER_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    always #5 clk = ~clk;

    frame_streamer #(
        .NO_CH        (NO_CH),
        .LOG2_IMG_SIZE(LOG2_IMG_SIZE),
        .SER_CYC      (SER_CYC),
        .GAP          (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_vld   (wr_vld),
        .wr_rdy   (wr_rdy),
        .wr_data  (wr_data),
        .vld_out  (vld_out),
        .data_out (data_out),
        .sof      (sof),
        .eof      (eof)
`ifdef FRAME_STREAMER_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    // Edge counter: after posedge k has been processed, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [NO_CH-1:0] exp_q[$];      // words of complete frames, in output order
    logic [NO_CH-1:0] part_q[$];     // words of the frame being written
    int               rdy_edge_q[$]; // earliest edge each queued frame may show sof
    int               cmpl_q[$];     // edge at which each frame became full
    int               held          = 0;
    int               out_idx       = 0;
    int               last_eof_edge = -1000;
    int               exp_frames    = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        part_q.delete();
        rdy_edge_q.delete();
        cmpl_q.delete();
        held          = 0;
        out_idx       = 0;
        last_eof_edge = -1000;
        exp_frames    = 0;
    endtask

    // Scoreboard monitor: samples on the falling edge.
    logic [NO_CH-1:0] exp_w;
    int               r_edge;
    int               s_edge;
    always @(negedge clk) begin
        while (cmpl_q.size() > 0 && cmpl_q[0] <= cyc) begin
            void'(cmpl_q.pop_front());
            held++;
        end
        if (vld_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0d expected no output (edge %0d)", data_out, cyc);
            end else begin
                exp_w = exp_q.pop_front();
                chk("data", data_out, exp_w);
                chk("sof", sof, out_idx == 0);
                chk("eof", eof, out_idx == DEPTH - 1);
                if (out_idx == 0) begin
                    if (rdy_edge_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sof_unexpected: got sof at edge %0d expected none", cyc);
                    end else begin
                        r_edge = rdy_edge_q.pop_front();
                        s_edge = (r_edge > last_eof_edge + GAP + 2) ? r_edge : last_eof_edge + GAP + 2;
                        chk("sof_edge", cyc, s_edge);
                    end
                end
                if (out_idx == DEPTH - 1) begin
                    last_eof_edge = cyc;
                    held--;
                    exp_frames++;
                    out_idx = 0;
                end else begin
                    out_idx++;
                end
            end
        end else begin
            chk("no_bubble", out_idx, 0);
            chk("markers_idle", {sof, eof}, 2'b00);
        end
        chk("wr_rdy", wr_rdy, held < 2);
`ifdef FRAME_STREAMER_CNT_EN
        chk("frame_cnt", frame_cnt, exp_frames[15:0]);
`endif
    end

    // Driver: one cycle of upstream activity; acc tells whether it is accepted.
    task automatic drive(input logic [NO_CH-1:0] d, input logic v, output logic acc);
        @(posedge clk);
        #1;
        wr_vld  = v;
        wr_data = d;
        acc     = v && wr_rdy;
        if (acc) begin
            part_q.push_back(d);
            if (part_q.size() == DEPTH) begin
                foreach (part_q[i]) exp_q.push_back(part_q[i]);
                part_q.delete();
                cmpl_q.push_back(cyc + 1);
                rdy_edge_q.push_back(cyc + 3);
            end
        end
    endtask

    task automatic idle_cycle();
        logic acc;
        drive('0, 1'b0, acc);
    endtask

    task automatic send_word(input logic [NO_CH-1:0] d);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
            drive(d, 1'b1, acc);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept of %0d", d);
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (out_idx == 0) && (rdy_edge_q.size() == 0);
        end
        chk("drain", done, 1'b1);
        repeat (GAP + 3) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        wr_vld = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_vld_out", vld_out, 1'b0);
        chk("rst_sof_eof", {sof, eof}, 2'b00);
        chk("rst_data_out", data_out, 0);
        chk("rst_wr_rdy", wr_rdy, 1'b1);
`ifdef FRAME_STREAMER_CNT_EN
        chk("rst_frame_cnt", frame_cnt, 0);
`endif
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        logic done;
        rst     = 1'b1;
        wr_vld  = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_vld_out", vld_out, 1'b0);
        chk("init_data_out", data_out, 0);
        chk("init_wr_rdy", wr_rdy, 1'b1);
        #2;
        rst = 1'b0;

        // Single frame, back-to-back writes of 0..7.
        for (int i = 0; i < DEPTH; i++) send_word(NO_CH'(i));
        idle_cycle();
        drain();

        // 24 continuous words: buffer fills, writer stalls, frames back-to-back.
        for (int i = 0; i < 3 * DEPTH; i++) send_word(NO_CH'(8 + i));
        idle_cycle();
        drain();

        // 0..7 with random 50% upstream gaps, then random-data frames.
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(0, 1) == 0) idle_cycle();
            send_word(NO_CH'(i));
        end
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                send_word(NO_CH'($urandom_range(0, 255)));
            end
        end
        idle_cycle();
        drain();

        // Reset mid-frame once word 3 has been emitted, then a clean frame.
        for (int i = 0; i < DEPTH; i++) send_word(NO_CH'(100 + i));
        idle_cycle();
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            done = (out_idx == 4);
        end
        chk("midframe_reached", done, 1'b1);
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) send_word(NO_CH'(150 + i));
        idle_cycle();
        drain();
`ifdef FRAME_STREAMER_CNT_EN
        chk("frame_cnt_after_reset", frame_cnt, 1);
`endif

        // Bank B completes on the edge bank A emits eof; bank A then refills at once.
        for (int i = 0; i < DEPTH; i++) send_word(NO_CH'(200 + i));
        idle_cycle();
        for (int i = 0; i < DEPTH; i++) send_word(NO_CH'(210 + i));
        for (int i = 0; i < DEPTH; i++) send_word(NO_CH'(230 + i));
        idle_cycle();
        drain();

        chk("exp_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
